// File: rtl/fetch_controller_if.sv
// Instruction-memory request/response and decode-side valid/ready bundle for fetch_controller.
// master = fetch controller side; slave = memory + decode side.
interface fetch_controller_if #(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned INSTR_WIDTH   = 32
);
  logic                     imem_req;
  logic [ADDRESS_WIDTH-1:0] imem_addr;
  logic                     imem_gnt;
  logic                     imem_rvalid;
  logic [INSTR_WIDTH-1:0]   imem_rdata;
  logic [INSTR_WIDTH-1:0]   instr;
  logic                     instr_valid;
  logic                     instr_ready;

  modport master (
    output imem_req, imem_addr, instr, instr_valid,
    input  imem_gnt, imem_rvalid, imem_rdata, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr, instr_valid,
    output imem_gnt, imem_rvalid, imem_rdata, instr_ready
  );
endinterface

// File: rtl/fetch_controller.sv
// Multi-cycle instruction fetch sequencer: REQ -> WAIT -> VALID per instruction, with a
// sticky timeout error covering the combined REQ+WAIT time of one fetch.
module fetch_controller #(
  parameter int unsigned ADDRESS_WIDTH  = 32,
  parameter int unsigned INSTR_WIDTH    = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                     clk,
  input  logic                     n_reset,
  input  logic                     start,
  input  logic [ADDRESS_WIDTH-1:0] pc,
  input  logic                     redirect,
  output logic                     pc_load,
  output logic                     pc_src,
  output logic                     busy,
  output logic                     fetch_error,
  fetch_controller_if.master       bus
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_VALID,
    S_ERROR
  } state_e;

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic                   err_q, err_d;
  logic                   timeout;

  always_ff @(posedge clk or posedge n_reset) begin
    if (n_reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      instr_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      instr_q <= instr_d;
      err_q   <= err_d;
    end
  end

  // >= rather than == so a fetch whose gnt lands on the final REQ cycle still cannot
  // sit in WAIT forever once the budget is spent.
  assign timeout = (cnt_q >= CNT_LAST);

  always_comb begin
    state_d           = state_q;
    cnt_d             = cnt_q;
    instr_d           = instr_q;
    err_d             = err_q;
    pc_load           = 1'b0;
    pc_src            = 1'b0;
    busy              = 1'b0;
    bus.imem_req      = 1'b0;
    bus.imem_addr     = '0;
    bus.instr_valid   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_REQ;
          cnt_d   = '0;
        end
      end
      S_REQ: begin
        busy          = 1'b1;
        bus.imem_req  = 1'b1;
        bus.imem_addr = pc;
        if (cnt_q != '1) cnt_d = cnt_q + CNT_ONE;
        if (bus.imem_gnt) begin
          state_d = S_WAIT;
        end else if (timeout) begin
          state_d = S_ERROR;
          err_d   = 1'b1;
          instr_d = '0;
        end
      end
      S_WAIT: begin
        busy = 1'b1;
        if (cnt_q != '1) cnt_d = cnt_q + CNT_ONE;
        if (bus.imem_rvalid) begin
          state_d = S_VALID;
          instr_d = bus.imem_rdata;
        end else if (timeout) begin
          state_d = S_ERROR;
          err_d   = 1'b1;
          instr_d = '0;
        end
      end
      S_VALID: begin
        busy            = 1'b1;
        bus.instr_valid = 1'b1;
        if (bus.instr_ready) begin
          pc_load = 1'b1;
          pc_src  = redirect;
          state_d = S_REQ;
          cnt_d   = '0;
        end
      end
      S_ERROR: begin
        err_d = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign bus.instr   = instr_q;
  assign fetch_error = err_q;

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller: basic fetch, decode back-pressure, redirect,
// timeout/error, reset mid-fetch, and a randomised-latency memory over 100 fetches.
module tb_fetch_controller;

  logic        clk = 1'b0;
  logic        n_reset;
  logic        start, start2;
  logic        redirect;
  logic [31:0] pc_r, pc_init, target;
  logic [31:0] pc2;
  logic        pc_load, pc_src, busy, fetch_error;
  logic        pc_load2, pc_src2, busy2, fetch_error2;

  int n_cmp  = 0;
  int n_err  = 0;
  int n_loads = 0;

  fetch_controller_if #(.ADDRESS_WIDTH(32), .INSTR_WIDTH(32)) bus ();
  fetch_controller_if #(.ADDRESS_WIDTH(32), .INSTR_WIDTH(32)) bus2 ();

  fetch_controller #(
    .ADDRESS_WIDTH(32), .INSTR_WIDTH(32), .TIMEOUT_CYCLES(255)
  ) dut (
    .clk(clk), .n_reset(n_reset), .start(start), .pc(pc_r), .redirect(redirect),
    .pc_load(pc_load), .pc_src(pc_src), .busy(busy), .fetch_error(fetch_error),
    .bus(bus)
  );

  fetch_controller #(
    .ADDRESS_WIDTH(32), .INSTR_WIDTH(32), .TIMEOUT_CYCLES(4)
  ) dut_to (
    .clk(clk), .n_reset(n_reset), .start(start2), .pc(pc2), .redirect(1'b0),
    .pc_load(pc_load2), .pc_src(pc_src2), .busy(busy2), .fetch_error(fetch_error2),
    .bus(bus2)
  );

  always #5 clk = ~clk;

  // Program counter of the surrounding pipeline: loads on pc_load, picks target or pc+4.
  always @(posedge clk or posedge n_reset) begin
    if (n_reset)      pc_r <= pc_init;
    else if (pc_load) pc_r <= pc_src ? target : pc_r + 32'd4;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    if (pc_load === 1'b1) n_loads++;
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] exp_addr, data, tgt;
    logic        redir;
    int unsigned d, r, w;

    n_reset = 1'b1; start = 1'b0; start2 = 1'b0; redirect = 1'b0;
    pc_init = 32'h0; target = 32'h0; pc2 = 32'h40;
    bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = '0; bus.instr_ready = 1'b0;
    bus2.imem_gnt = 1'b0; bus2.imem_rvalid = 1'b0; bus2.imem_rdata = '0; bus2.instr_ready = 1'b0;

    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_instr",   bus.instr, 32'h0);
    check_eq("rst_ivalid",  32'(bus.instr_valid), 32'h0);
    check_eq("rst_err",     32'(fetch_error), 32'h0);
    check_eq("rst_pcload",  32'(pc_load), 32'h0);
    check_eq("rst_pcsrc",   32'(pc_src), 32'h0);
    check_eq("rst_req",     32'(bus.imem_req), 32'h0);
    check_eq("rst_addr",    bus.imem_addr, 32'h0);
    check_eq("rst_busy",    32'(busy), 32'h0);
    check_eq("rst_err2",    32'(fetch_error2), 32'h0);
    @(negedge clk);
    n_reset = 1'b0;

    // Basic fetch at pc=0 with zero-wait memory
    start = 1'b1; bus.imem_gnt = 1'b1; #1;
    check_eq("idle_req", 32'(bus.imem_req), 32'h0);
    check_eq("idle_busy", 32'(busy), 32'h0);
    @(negedge clk);
    start = 1'b0; #1;
    check_eq("b_req", 32'(bus.imem_req), 32'h1);
    check_eq("b_addr", bus.imem_addr, 32'h0);
    check_eq("b_busy", 32'(busy), 32'h1);
    @(negedge clk);
    bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h00500093; #1;
    check_eq("b_wait_req", 32'(bus.imem_req), 32'h0);
    check_eq("b_wait_iv", 32'(bus.instr_valid), 32'h0);
    @(negedge clk);
    bus.imem_rvalid = 1'b0; bus.imem_rdata = '0; bus.instr_ready = 1'b1; #1;
    check_eq("b_iv", 32'(bus.instr_valid), 32'h1);
    check_eq("b_instr", bus.instr, 32'h00500093);
    check_eq("b_pcload", 32'(pc_load), 32'h1);
    check_eq("b_pcsrc", 32'(pc_src), 32'h0);
    @(negedge clk);
    bus.instr_ready = 1'b0; #1;
    check_eq("b_next_addr", bus.imem_addr, 32'h4);
    check_eq("b_next_req", 32'(bus.imem_req), 32'h1);
    check_eq("b_next_pcload", 32'(pc_load), 32'h0);

    // Decode back-pressure for 10 cycles
    bus.imem_gnt = 1'b1;
    @(negedge clk);
    bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h11111111;
    @(negedge clk);
    bus.imem_rvalid = 1'b0; bus.imem_rdata = '0;
    for (int i = 0; i < 10; i++) begin
      #1;
      check_eq("hold_iv", 32'(bus.instr_valid), 32'h1);
      check_eq("hold_instr", bus.instr, 32'h11111111);
      check_eq("hold_pcload", 32'(pc_load), 32'h0);
      @(negedge clk);
    end
    bus.instr_ready = 1'b1; #1;
    check_eq("hold_hs_pcload", 32'(pc_load), 32'h1);
    check_eq("hold_hs_pcsrc", 32'(pc_src), 32'h0);
    @(negedge clk);
    bus.instr_ready = 1'b0; #1;
    check_eq("hold_after_pcload", 32'(pc_load), 32'h0);
    check_eq("hold_after_addr", bus.imem_addr, 32'h8);

    // Redirect: held high through WAIT, only honoured at the handshake
    bus.imem_gnt = 1'b1; redirect = 1'b1; target = 32'h100;
    @(negedge clk);
    bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'h22222222; #1;
    check_eq("rd_wait_pcsrc", 32'(pc_src), 32'h0);
    check_eq("rd_wait_pcload", 32'(pc_load), 32'h0);
    @(negedge clk);
    bus.imem_rvalid = 1'b0; bus.imem_rdata = '0; bus.instr_ready = 1'b1; #1;
    check_eq("rd_hs_pcload", 32'(pc_load), 32'h1);
    check_eq("rd_hs_pcsrc", 32'(pc_src), 32'h1);
    @(negedge clk);
    bus.instr_ready = 1'b0; redirect = 1'b0; #1;
    check_eq("rd_next_addr", bus.imem_addr, 32'h100);
    check_eq("rd_next_req", 32'(bus.imem_req), 32'h1);

    // Reset while in WAIT; a late rvalid must be ignored
    bus.imem_gnt = 1'b1;
    @(negedge clk);
    bus.imem_gnt = 1'b0; #1;
    check_eq("mr_wait_busy", 32'(busy), 32'h1);
    n_reset = 1'b1; #1;
    check_eq("mr_rst_busy", 32'(busy), 32'h0);
    @(negedge clk);
    n_reset = 1'b0; bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    bus.imem_rvalid = 1'b0; bus.imem_rdata = '0; #1;
    check_eq("mr_iv", 32'(bus.instr_valid), 32'h0);
    check_eq("mr_instr", bus.instr, 32'h0);
    check_eq("mr_busy", 32'(busy), 32'h0);
    check_eq("mr_req", 32'(bus.imem_req), 32'h0);
    @(negedge clk); #1;
    check_eq("mr_idle_busy", 32'(busy), 32'h0);

    // TIMEOUT_CYCLES=4: gnt on the last allowed REQ cycle still completes
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1; check_eq("tb_req", 32'(bus2.imem_req), 32'h1);
      @(negedge clk);
    end
    bus2.imem_gnt = 1'b1; #1;
    check_eq("tb_last_req", 32'(bus2.imem_req), 32'h1);
    @(negedge clk);
    bus2.imem_gnt = 1'b0; bus2.imem_rvalid = 1'b1; bus2.imem_rdata = 32'hCAFE0001; #1;
    check_eq("tb_wait_err", 32'(fetch_error2), 32'h0);
    @(negedge clk);
    bus2.imem_rvalid = 1'b0; bus2.imem_rdata = '0; bus2.instr_ready = 1'b1; #1;
    check_eq("tb_iv", 32'(bus2.instr_valid), 32'h1);
    check_eq("tb_instr", bus2.instr, 32'hCAFE0001);
    @(negedge clk);
    bus2.instr_ready = 1'b0;
    // Counter restarted on re-entry to REQ: exactly 4 REQ cycles before ERROR
    for (int i = 0; i < 4; i++) begin
      #1;
      check_eq("to_req", 32'(bus2.imem_req), 32'h1);
      check_eq("to_err_pre", 32'(fetch_error2), 32'h0);
      @(negedge clk);
    end
    #1;
    check_eq("to_err", 32'(fetch_error2), 32'h1);
    check_eq("to_req_off", 32'(bus2.imem_req), 32'h0);
    check_eq("to_busy", 32'(busy2), 32'h0);
    bus2.imem_gnt = 1'b1; bus2.imem_rvalid = 1'b1; bus2.imem_rdata = 32'h12345678; start2 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      check_eq("to_late_err", 32'(fetch_error2), 32'h1);
      check_eq("to_late_iv", 32'(bus2.instr_valid), 32'h0);
      check_eq("to_late_req", 32'(bus2.imem_req), 32'h0);
      check_eq("to_late_instr", bus2.instr, 32'h0);
    end
    bus2.imem_gnt = 1'b0; bus2.imem_rvalid = 1'b0; bus2.imem_rdata = '0; start2 = 1'b0;

    // Reset clears the sticky error; PC restarts at 0x1000 for the random run
    pc_init = 32'h1000;
    @(negedge clk);
    n_reset = 1'b1;
    @(negedge clk);
    n_reset = 1'b0; #1;
    check_eq("to_rst_err", 32'(fetch_error2), 32'h0);

    // Random-latency memory, 100 fetches
    exp_addr = 32'h1000;
    n_loads = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int f = 0; f < 100; f++) begin
      d = $urandom_range(0, 3);
      for (int k = 0; k < int'(d); k++) begin
        bus.imem_gnt = 1'b0; #1;
        check_eq("rnd_req_hold", 32'(bus.imem_req), 32'h1);
        check_eq("rnd_addr_hold", bus.imem_addr, exp_addr);
        next_cycle();
      end
      bus.imem_gnt = 1'b1; #1;
      check_eq("rnd_req", 32'(bus.imem_req), 32'h1);
      check_eq("rnd_addr", bus.imem_addr, exp_addr);
      next_cycle();
      bus.imem_gnt = 1'b0;
      r = $urandom_range(1, 3);
      for (int k = 0; k < int'(r) - 1; k++) begin
        #1;
        check_eq("rnd_wait_req", 32'(bus.imem_req), 32'h0);
        next_cycle();
      end
      data = $urandom;
      bus.imem_rvalid = 1'b1; bus.imem_rdata = data; #1;
      check_eq("rnd_wait_req", 32'(bus.imem_req), 32'h0);
      next_cycle();
      bus.imem_rvalid = 1'b0; bus.imem_rdata = '0;
      w = $urandom_range(0, 2);
      for (int k = 0; k < int'(w); k++) begin
        #1;
        check_eq("rnd_iv_hold", 32'(bus.instr_valid), 32'h1);
        check_eq("rnd_instr_hold", bus.instr, data);
        check_eq("rnd_pcload_hold", 32'(pc_load), 32'h0);
        next_cycle();
      end
      redir = 1'($urandom_range(0, 1));
      tgt = $urandom & 32'hFFFF_FFFC;
      redirect = redir; target = tgt; bus.instr_ready = 1'b1; #1;
      check_eq("rnd_iv", 32'(bus.instr_valid), 32'h1);
      check_eq("rnd_instr", bus.instr, data);
      check_eq("rnd_pcload", 32'(pc_load), 32'h1);
      check_eq("rnd_pcsrc", 32'(pc_src), 32'(redir));
      next_cycle();
      bus.instr_ready = 1'b0; redirect = 1'b0;
      exp_addr = redir ? tgt : exp_addr + 32'd4;
    end
    #1;
    check_eq("rnd_final_addr", bus.imem_addr, exp_addr);
    check_eq("rnd_loads", 32'(n_loads), 32'd100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
